blind_pixel_decode: RTL and testbench

// Avalon-ST video sink-side parser, the stage directly downstream of blind_pixel_encode.

---
 rtl/blind_pixel_decode_if.sv | 27 ++
 rtl/blind_pixel_decode.sv | 174 +++++++++++++++++
 tb/tb_blind_pixel_decode.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blind_pixel_decode_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blind_pixel_decode_if
// Purpose  : Avalon-ST video beat bundle (data, valid, SOP, EOP, ready).
// Revision : 1.0
// ============================================================================
interface blind_pixel_decode_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  startofpacket;
    logic                  endofpacket;
    logic                  ready;

    modport master (
        output data, valid, startofpacket, endofpacket,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/blind_pixel_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : blind_pixel_decode
// Purpose  : Avalon-ST video sink parser: latches control packets, forwards
//            data packet pixels with fresh SOP/EOP, discards other types.
// Revision : 1.0
// ============================================================================
module blind_pixel_decode #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_BITS   = 8,
    parameter int DATA_PLANES = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    blind_pixel_decode_if.slave    din,
    blind_pixel_decode_if.master   dout,
    output logic [15:0]            video_width,
    output logic [15:0]            video_height,
    output logic [3:0]             video_interlaced,
    output logic                   ctrl_update,
    output logic                   pkt_error
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ctrl = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_skip = 2'd3;

    // Beats after the type beat needed to carry all nine nibbles.
    localparam int         c_cb_beats = (DATA_PLANES >= 3) ? 3 : (DATA_PLANES == 2) ? 5 : 9;
    localparam logic [3:0] c_cb       = 4'(c_cb_beats);
    localparam logic [3:0] c_cb_last  = 4'(c_cb_beats - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  bc_q, bc_d;
    logic        first_q, first_d;
    logic [35:0] shadow_q, shadow_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [3:0]  interlaced_q, interlaced_d;
    logic        ctrl_update_q, ctrl_update_d;
    logic        pkt_error_q, pkt_error_d;

    logic        w_accept;
    logic [3:0]  w_type;

    assign w_accept = din.valid && din.ready;
    assign w_type   = din.data[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= c_st_idle;
            bc_q          <= 4'd0;
            first_q       <= 1'b0;
            shadow_q      <= 36'd0;
            width_q       <= 16'd0;
            height_q      <= 16'd0;
            interlaced_q  <= 4'd0;
            ctrl_update_q <= 1'b0;
            pkt_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bc_q          <= bc_d;
            first_q       <= first_d;
            shadow_q      <= shadow_d;
            width_q       <= width_d;
            height_q      <= height_d;
            interlaced_q  <= interlaced_d;
            ctrl_update_q <= ctrl_update_d;
            pkt_error_q   <= pkt_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bc_d          = bc_q;
        first_d       = first_q;
        shadow_d      = shadow_q;
        width_d       = width_q;
        height_d      = height_q;
        interlaced_d  = interlaced_q;
        ctrl_update_d = 1'b0;
        pkt_error_d   = 1'b0;

        if (w_accept) begin
            if (din.startofpacket) begin
                // A SOP anywhere but IDLE abandons the packet in flight.
                if (state_q != c_st_idle) begin
                    pkt_error_d = 1'b1;
                end
                bc_d    = 4'd0;
                first_d = 1'b1;
                if (din.endofpacket) begin
                    state_d = c_st_idle;
                    if (w_type == 4'hF) begin
                        pkt_error_d = 1'b1;
                    end
                end else begin
                    case (w_type)
                        4'hF:    state_d = c_st_ctrl;
                        4'h0:    state_d = c_st_data;
                        default: state_d = c_st_skip;
                    endcase
                end
            end else begin
                case (state_q)
                    c_st_ctrl: begin
                        if (bc_q < c_cb) begin
                            for (int p = 0; p < DATA_PLANES; p++) begin
                                if (int'(bc_q) * DATA_PLANES + p < 9) begin
                                    shadow_d[(int'(bc_q) * DATA_PLANES + p) * 4 +: 4] =
                                        din.data[p * DATA_BITS +: 4];
                                end
                            end
                        end
                        if (bc_q != 4'hF) begin
                            bc_d = bc_q + 4'd1;
                        end
                        if (din.endofpacket) begin
                            state_d = c_st_idle;
                            if (bc_q >= c_cb_last) begin
                                // Nibble 0 is the most significant of each field.
                                width_d       = {shadow_d[3:0],   shadow_d[7:4],
                                                 shadow_d[11:8],  shadow_d[15:12]};
                                height_d      = {shadow_d[19:16], shadow_d[23:20],
                                                 shadow_d[27:24], shadow_d[31:28]};
                                interlaced_d  = shadow_d[35:32];
                                ctrl_update_d = 1'b1;
                            end else begin
                                pkt_error_d = 1'b1;
                            end
                        end
                    end
                    c_st_data: begin
                        first_d = 1'b0;
                        if (din.endofpacket) begin
                            state_d = c_st_idle;
                        end
                    end
                    c_st_skip: begin
                        if (din.endofpacket) begin
                            state_d = c_st_idle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        din.ready          = 1'b1;
        dout.data          = din.data;
        dout.valid         = 1'b0;
        dout.startofpacket = 1'b0;
        dout.endofpacket   = 1'b0;
        // An aborting SOP in DATA is swallowed rather than forwarded.
        if (state_q == c_st_data && !(din.valid && din.startofpacket)) begin
            din.ready          = dout.ready;
            dout.valid         = din.valid;
            dout.startofpacket = first_q && din.valid;
            dout.endofpacket   = din.endofpacket;
        end
    end

    assign video_width      = width_q;
    assign video_height     = height_q;
    assign video_interlaced = interlaced_q;
    assign ctrl_update      = ctrl_update_q;
    assign pkt_error        = pkt_error_q;

endmodule
`default_nettype wire

// File: tb/tb_blind_pixel_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_blind_pixel_decode
// Purpose  : Scoreboard bench for blind_pixel_decode (1-plane and 3-plane).
// Revision : 1.0
// ============================================================================
module tb_blind_pixel_decode;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } pix_t;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  i;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pix_t  pix_q1[$];
    ctrl_t ctrl_q1[$];
    ctrl_t ctrl_q3[$];
    int    err_q1[$];

    blind_pixel_decode_if #(.DATA_WIDTH(8))  din1();
    blind_pixel_decode_if #(.DATA_WIDTH(8))  dout1();
    blind_pixel_decode_if #(.DATA_WIDTH(24)) din3();
    blind_pixel_decode_if #(.DATA_WIDTH(24)) dout3();

    logic [15:0] vw1, vh1, vw3, vh3;
    logic [3:0]  vi1, vi3;
    logic        cu1, pe1, cu3, pe3;

    blind_pixel_decode #(.DATA_WIDTH(8), .DATA_BITS(8), .DATA_PLANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .dout(dout1),
        .video_width(vw1), .video_height(vh1), .video_interlaced(vi1),
        .ctrl_update(cu1), .pkt_error(pe1)
    );

    blind_pixel_decode #(.DATA_WIDTH(24), .DATA_BITS(8), .DATA_PLANES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .dout(dout3),
        .video_width(vw3), .video_height(vh3), .video_interlaced(vi3),
        .ctrl_update(cu3), .pkt_error(pe3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Monitors sample on the falling edge, between input changes and capture.
    always @(negedge clk) begin
        if (dout1.valid === 1'b1 && dout1.ready === 1'b1) begin
            if (pix_q1.size() == 0) fail_event("dout1_extra_beat");
            else chk("dout1_beat", {dout1.data, dout1.startofpacket, dout1.endofpacket},
                     pix_q1.pop_front());
        end
        if (cu1 === 1'b1) begin
            if (ctrl_q1.size() == 0) fail_event("ctrl_update1_extra");
            else chk("video1_fields", {vw1, vh1, vi1}, ctrl_q1.pop_front());
        end
        if (pe1 === 1'b1) begin
            if (err_q1.size() == 0) fail_event("pkt_error1_extra");
            else void'(err_q1.pop_front());
        end
        if (dout3.valid === 1'b1) fail_event("dout3_unexpected_beat");
        if (pe3 === 1'b1) fail_event("pkt_error3_unexpected");
        if (cu3 === 1'b1) begin
            if (ctrl_q3.size() == 0) fail_event("ctrl_update3_extra");
            else chk("video3_fields", {vw3, vh3, vi3}, ctrl_q3.pop_front());
        end
    end

    task automatic b1(input logic [7:0] d, input logic s, input logic e, input int stall);
        int guard;
        din1.data = d; din1.startofpacket = s; din1.endofpacket = e; din1.valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            dout1.ready = 1'b0;
            @(negedge clk);
            chk("din_ready_mirrors_stall", {63'd0, din1.ready}, 64'd0);
            @(posedge clk); #1;
        end
        dout1.ready = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (din1.ready === 1'b1) break;
            guard++;
            if (guard > 50) begin
                fail_event("din1_ready_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        din1.valid = 1'b0; din1.startofpacket = 1'b0; din1.endofpacket = 1'b0;
    endtask

    task automatic b3(input logic [23:0] d, input logic s, input logic e);
        int guard;
        din3.data = d; din3.startofpacket = s; din3.endofpacket = e; din3.valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (din3.ready === 1'b1) break;
            guard++;
            if (guard > 50) begin
                fail_event("din3_ready_timeout");
                break;
            end
        end
        @(posedge clk); #1;
        din3.valid = 1'b0; din3.startofpacket = 1'b0; din3.endofpacket = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ctrl_a [10];
        logic [7:0] ctrl_b [10];
        ctrl_a = '{8'h0F, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h01, 8'h0E, 8'h00, 8'h00};
        ctrl_b = '{8'h0F, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h03};

        din1.data = '0; din1.valid = 1'b0; din1.startofpacket = 1'b0; din1.endofpacket = 1'b0;
        din3.data = '0; din3.valid = 1'b0; din3.startofpacket = 1'b0; din3.endofpacket = 1'b0;
        dout1.ready = 1'b1; dout3.ready = 1'b1;
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        chk("reset_video1", {vw1, vh1, vi1}, 64'd0);
        chk("reset_pulses1", {62'd0, cu1, pe1}, 64'd0);
        chk("reset_dout1_valid", {63'd0, dout1.valid}, 64'd0);
        chk("reset_video3", {vw3, vh3, vi3}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // 640x480 progressive, one plane
        ctrl_q1.push_back('{w: 16'h0280, h: 16'h01E0, i: 4'h0});
        for (int i = 0; i < 10; i++) b1(ctrl_a[i], i == 0, i == 9, 0);
        idle(3);

        // Three planes: upper nibble of each plane must be ignored
        ctrl_q3.push_back('{w: 16'h0780, h: 16'h0438, i: 4'h0});
        b3(24'h00000F, 1'b1, 1'b0);
        b3(24'h58A730, 1'b0, 1'b0);
        b3(24'h040000, 1'b0, 1'b0);
        b3(24'h000803, 1'b0, 1'b1);
        idle(3);

        // Data packet with downstream stalling on the second pixel
        pix_q1.push_back('{d: 8'h0A, s: 1'b1, e: 1'b0});
        pix_q1.push_back('{d: 8'h0B, s: 1'b0, e: 1'b0});
        pix_q1.push_back('{d: 8'h0C, s: 1'b0, e: 1'b1});
        b1(8'h00, 1'b1, 1'b0, 0);
        b1(8'h0A, 1'b0, 1'b0, 0);
        b1(8'h0B, 1'b0, 1'b0, 1);
        b1(8'h0C, 1'b0, 1'b1, 0);
        idle(3);

        // Short control packet: error, fields hold
        err_q1.push_back(1);
        b1(8'h0F, 1'b1, 1'b0, 0);
        b1(8'h00, 1'b0, 1'b0, 0);
        b1(8'h02, 1'b0, 1'b1, 0);
        idle(3);
        @(negedge clk);
        chk("short_ctrl_hold", {vw1, vh1, vi1}, {16'h0280, 16'h01E0, 4'h0});
        @(posedge clk); #1;

        // Unknown type skipped, then a one-pixel frame
        b1(8'h03, 1'b1, 1'b0, 0);
        for (int i = 1; i < 5; i++) b1(8'(i), 1'b0, i == 4, 0);
        pix_q1.push_back('{d: 8'h55, s: 1'b1, e: 1'b1});
        b1(8'h00, 1'b1, 1'b0, 0);
        b1(8'h55, 1'b0, 1'b1, 0);
        idle(3);

        // Data packet aborted by a new data SOP
        pix_q1.push_back('{d: 8'h11, s: 1'b1, e: 1'b0});
        pix_q1.push_back('{d: 8'h22, s: 1'b0, e: 1'b0});
        pix_q1.push_back('{d: 8'h33, s: 1'b1, e: 1'b1});
        err_q1.push_back(1);
        b1(8'h00, 1'b1, 1'b0, 0);
        b1(8'h11, 1'b0, 1'b0, 0);
        b1(8'h22, 1'b0, 1'b0, 0);
        b1(8'h00, 1'b1, 1'b0, 0);
        b1(8'h33, 1'b0, 1'b1, 0);
        idle(3);

        // Single-beat control packet is malformed
        err_q1.push_back(1);
        b1(8'h0F, 1'b1, 1'b1, 0);
        idle(3);

        // Interlace nibble non-zero
        ctrl_q1.push_back('{w: 16'h0100, h: 16'h0080, i: 4'h3});
        for (int i = 0; i < 10; i++) b1(ctrl_b[i], i == 0, i == 9, 0);
        idle(3);

        // Reset in the middle of a control packet clears everything
        b1(8'h0F, 1'b1, 1'b0, 0);
        b1(8'h01, 1'b0, 1'b0, 0);
        b1(8'h02, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        chk("midpkt_reset_video1", {vw1, vh1, vi1}, 64'd0);
        chk("midpkt_reset_video3", {vw3, vh3, vi3}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5);

        chk("pix_queue_drained", 64'(pix_q1.size()), 64'd0);
        chk("ctrl1_queue_drained", 64'(ctrl_q1.size()), 64'd0);
        chk("ctrl3_queue_drained", 64'(ctrl_q3.size()), 64'd0);
        chk("err_queue_drained", 64'(err_q1.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
